sram_axi_bridge: RTL
====================

// Module: sram_axi_bridge
// PURPOSE
//  Converts the CPU's two SRAM-like request ports (instruction fetch, data access) into a single AXI3 master.
//  Sits between the CPU top and the SoC crossbar, and replaces the direct inst_sram/data_sram hookup.
//  Only one AXI transaction is outstanding at any time. A data request beats a pending fetch.
//  Transactions are single-beat only.
// PARAMETERS
//  ADDR_W  32  address width, applied to both request ports and AXI addresses
//  DATA_W  32  data width; the bridge supports 32 only
// PORTS
//  clk           in   1      single clock; all logic on its rising edge
//  rst           in   1      synchronous reset, active-high
//  inst_req      in   1      fetch request valid
//  inst_addr     in   32     fetch physical address (word aligned)
//  inst_addr_ok  out  1      fetch request accepted this cycle
//  inst_data_ok  out  1      one-cycle pulse: inst_rdata valid
//  inst_rdata    out  32     fetched instruction
//  data_req      in   1      data request valid
//  data_wr       in   1      1=store, 0=load
//  data_size     in   2      0=byte, 1=half, 2=word
//  data_addr     in   32     data physical address
//  data_wdata    in   32     store data (already lane-aligned)
//  data_addr_ok  out  1      data request accepted this cycle
//  data_data_ok  out  1      one-cycle pulse: load data valid or store done
//  data_rdata    out  32     load data (raw word)
//  araddr/arsize out  32/3   AXI read address and size
//  arvalid/arready out/in 1  AR handshake
//  rdata         in   32     AXI read data
//  rvalid/rready in/out 1    R handshake (rresp ignored)
//  awaddr/awsize out  32/3   AXI write address and size
//  awvalid/awready out/in 1  AW handshake
//  wdata/wstrb   out  32/4   AXI write data and byte strobes (wlast tied 1 in wrapper)
//  wvalid/wready out/in 1    W handshake
//  bvalid/bready in/out 1    B handshake (bresp ignored)
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge):
//    - state goes to IDLE.
//    - All *valid, *ready, *_addr_ok and *_data_ok outputs go to 0.
//    - rdata registers and address registers clear to 0.
//    - A reset during a transaction abandons it; the crossbar is reset in the same cycle.
//  - Constant AXI fields are tied in the wrapper: id=0, len=0, burst=INCR, lock/cache/prot=0.
//  - FSM states and transitions:
//    - IDLE -> RD_AR on an accepted load or fetch.
//    - IDLE -> WR_AW on an accepted store.
//    - RD_AR -> RD_R on arvalid&&arready.
//    - RD_R -> IDLE on rvalid&&rready.
//    - WR_AW -> WR_B once both AW and W have handshaken; they may complete in either order or the same cycle.
//    - WR_B -> IDLE on bvalid&&bready.
//  - Acceptance:
//    - Requests are accepted only in IDLE, combinationally.
//    - data_addr_ok = IDLE & data_req.
//    - inst_addr_ok = IDLE & inst_req & ~data_req.
//    - Both ports requesting in the same cycle: data wins; the fetch waits and is not dropped.
//    - On acceptance the bridge latches addr, size, wdata, wr and an owner bit (inst/data).
//    - Requests arriving outside IDLE are held off: addr_ok stays 0.
//  - AXI size and strobes:
//    - Fetch uses arsize=2.
//    - Data uses arsize/awsize = {1'b0, data_size}.
//    - wstrb: size0 -> 4'b0001<<addr[1:0]; size1 -> 4'b0011<<addr[1:0]; size2 -> 4'b1111.
//    - Misaligned addresses are not checked here; they are trapped upstream.
//  - Valid/ready rules:
//    - arvalid is high for the whole of RD_AR.
//    - awvalid and wvalid rise on entry to WR_AW; each drops after its own handshake.
//    - rready=1 only in RD_R; bready=1 only in WR_B.
//  - Response:
//    - On the R handshake, rdata is registered into the owner's rdata register.
//    - The owner's data_ok pulses for exactly one cycle, the cycle after the handshake. IDLE is re-entered in that same cycle.
//    - A store pulses data_data_ok the cycle after the B handshake.
//    - rdata holds its value until the next response for that port.
//  - Latency with zero-wait slave:
//    - Load or fetch: req at cycle t -> data_ok at t+3.
//    - Store: req at cycle t -> data_ok at t+3.
//    - Back-to-back issue is allowed: a new request can be accepted in the data_ok cycle.
//  - Throughput: one transaction per 3 cycles at best.
// TESTING
//  - Fetch, zero-wait slave: inst_req=1, addr=0x1FC00000 at t0 -> arvalid t1, araddr=0x1FC00000, arsize=2; rdata=0x3C08BFAF at t2 -> inst_data_ok=1, inst_rdata=0x3C08BFAF at t3 only.
//  - Collision: inst_req and data_req (load, 0x00001004) both at t0 -> data_addr_ok=1, inst_addr_ok=0; the fetch is accepted at t3 and its AR follows the data read.
//  - Byte store: size=0, addr=0x00002003, wdata=0xAB000000 -> wstrb=4'b1000, awsize=0; AW accepted before W (wready delayed 3 cycles) -> bready only after both handshakes; data_data_ok one cycle after bvalid.
//  - Backpressure: arready held 0 for 5 cycles -> arvalid and araddr stable throughout; no addr_ok granted to either port meanwhile.
//  - Reset mid-read: rst=1 in RD_R -> next cycle state IDLE, rready=0, no data_ok pulse, all outputs at reset values.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's instruction-fetch and data SRAM-like ports onto one AXI3 master.
// One single-beat transaction in flight at a time; data requests take priority over fetches.
module sram_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,

    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_AR = 3'd1,
        RD_R  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        size_r;
    logic [DATA_W-1:0] wdata_r;
    logic              owner_data;
    logic              aw_done;
    logic              w_done;

    // Every channel transfers on a rising edge where both valid and ready are high.
    // The bridge never drops a valid it has raised until that transfer happens,
    // and it never makes its own valid depend on the slave's ready.
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid  & rready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid  & wready;
    assign b_hs  = bvalid  & bready;

    // Acceptance is combinational so a request can be taken in the same cycle it appears.
    assign data_addr_ok = (state == IDLE) & data_req;
    assign inst_addr_ok = (state == IDLE) & inst_req & ~data_req;

    assign araddr    = addr_r;
    assign arsize    = size_r;
    assign awaddr    = addr_r;
    assign awsize    = size_r;
    assign wdata     = wdata_r;
    assign state_dbg = state;

    always_comb begin
        wstrb = 4'b0000;
        case (size_r[1:0])
            2'd0:    wstrb = 4'b0001 << addr_r[1:0];
            2'd1:    wstrb = 4'b0011 << addr_r[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_r       <= '0;
            size_r       <= '0;
            wdata_r      <= '0;
            owner_data   <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_addr_ok) begin
                        addr_r     <= data_addr;
                        size_r     <= {1'b0, data_size};
                        wdata_r    <= data_wdata;
                        owner_data <= 1'b1;
                        if (data_wr) begin
                            state   <= WR_AW;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state   <= RD_AR;
                            arvalid <= 1'b1;
                        end
                    end else if (inst_addr_ok) begin
                        addr_r     <= inst_addr;
                        size_r     <= 3'd2;
                        owner_data <= 1'b0;
                        state      <= RD_AR;
                        arvalid    <= 1'b1;
                    end
                end
                RD_AR: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (r_hs) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                        if (owner_data) begin
                            data_rdata   <= rdata;
                            data_data_ok <= 1'b1;
                        end else begin
                            inst_rdata   <= rdata;
                            inst_data_ok <= 1'b1;
                        end
                    end
                end
                WR_AW: begin
                    // AW and W complete independently; move on once both have gone.
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (b_hs) begin
                        bready       <= 1'b0;
                        data_data_ok <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
